head_prune_accum: RTL and testbench
===================================

Name: head_prune_accum

Overview:
- Parametrised successor of the Q*K head-prune detector.
- Accepts a stream of signed Q*K sub-result beats (LANES lanes per beat) over a valid/ready handshake and accumulates the absolute values with saturation.
- After a programmed number of beats, compares the shifted total against a runtime threshold and reports a per-head prune decision with a done pulse.
- Sits between the systolic-array result bus and the head scheduler.

Parameters:
- WIDTH, 8, operand width; each lane result is signed 2*WIDTH bits.
- LANES, 32, lane results per input beat.
- CNT_W, 8, width of the beat counter and num_beats.
- ACC_W, 2*WIDTH+$clog2(LANES)+8 (=29), accumulator width, unsigned.

Ports:
- clk  in  1  clock, rising edge.
- _reset  in  1  synchronous active-low reset.
- start  in  1  pulse; latches configuration and clears the accumulator (ignored unless IDLE/DONE).
- num_beats  in  CNT_W  beats to accumulate, sampled on start.
- threshold  in  ACC_W  unsigned compare threshold, sampled on start.
- cmp_shift  in  5  right shift applied to the total before compare, sampled on start.
- in_valid  in  1  input beat valid.
- in_ready  out  1  high only in ACCUM.
- in_data  in  LANES*2*WIDTH  packed signed lanes; lane i = [i*2*WIDTH +: 2*WIDTH].
- busy  out  1  state not IDLE/DONE.
- done  out  1  one-cycle pulse when prune_head is valid.
- prune_head  out  1  (acc >> cmp_shift) <= threshold; held until next start.
- overflow  out  1  sticky; accumulator saturated during this head.

Behaviour:
- Reset (_reset low at posedge): state IDLE; in_ready, busy, done, prune_head, overflow = 0; accumulator, pipeline registers, beat counter and valid bits = 0. A reset mid-operation discards in-flight beats; no done pulse is produced.
- FSM states:
  - IDLE/DONE --start--> ACCUM, or --start--> COMPARE if num_beats == 0.
  - ACCUM --accepted beat with count+1 == num_beats--> DRAIN.
  - DRAIN --pipeline empty--> COMPARE.
  - COMPARE --> DONE (one cycle).
  - DONE is IDLE with results held.
- A beat is accepted when in_valid && in_ready at posedge; gaps are allowed. No beats are accepted outside ACCUM.
- Pipeline:
  - Stage 1 (accept edge E): registers |lane| per lane as an unsigned 2*WIDTH value. |-2^(2*WIDTH-1)| = 2^(2*WIDTH-1), with no wrap.
  - Stage 2 (E+1): registers the adder-tree sum, width 2*WIDTH+$clog2(LANES).
  - Stage 3 (E+2): acc <= sat(acc + sum).
- Saturation: if acc + sum exceeds 2^ACC_W-1, acc = 2^ACC_W-1 and overflow = 1 (sticky until next start).
- COMPARE (E+3 for the last beat): registers prune_head = ((acc >> cmp_shift) <= threshold) and asserts done for exactly one cycle. done is visible in the cycle after edge E+3, giving 4-cycle latency.
- num_beats = 0: acc = 0, so prune_head = 1. done is visible 2 cycles after the start edge.
- start while busy: ignored, with no effect on configuration or accumulator.
- start in the same cycle as done: accepted; the new head begins and prune_head is cleared to 0.

Decomposition:
- Package head_prune_pkg holds:
  - the state enum (IDLE, ACCUM, DRAIN, COMPARE, DONE);
  - the ACC_W default function;
  - the lane-slice width constant LANE_W = 2*WIDTH.
- Sub-module abs_sum_tree (parameters WIDTH, LANES) implements stages 1–2 (registered abs plus a registered adder tree) with a valid bit. The top level holds the FSM, counter, accumulator and compare.

Test Plan:
1. Basic sum and threshold edge. WIDTH=8, LANES=32, all lanes +3, num_beats=4, cmp_shift=0.
   - threshold=384 -> acc=384, prune_head=1, done 4 cycles after last accept.
   - Rerun with threshold=383 -> prune_head=0.
2. Most-negative input. All lanes 0x8000, 1 beat, cmp_shift=8, threshold=4096 -> acc=1,048,576, shifted value 4096, prune_head=1, overflow=0.
3. Mixed signs with backpressure. Lanes alternate +5/-5, 2 beats, in_valid toggled 1-0-0-1 -> acc=320. Count beats only on handshake; a mid-run start is ignored; shift 0 with threshold 319 -> prune_head=0.
4. Saturation. ACC_W=20, lanes 0x7FFF, 2 beats -> acc=0xFFFFF, overflow=1. The next start clears overflow.
5. Zero beats. num_beats=0, threshold=0 -> in_ready never rises, done 2 cycles after start, prune_head=1.
6. Reset mid-ACCUM. _reset low after 1 of 3 beats -> all outputs 0, no done. A new start with 1 beat of all +1 and threshold 31 -> acc=32, prune_head=0.

Source files
------------

// File: rtl/head_prune_accum_pkg.sv
// Shared types and sizing helpers for the head-prune accumulator.
package head_prune_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCUM   = 3'd1,
    DRAIN   = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LANES = 32;

  function automatic int lane_w(input int width);
    return 2 * width;
  endfunction

  localparam int LANE_W = lane_w(DEF_WIDTH);

  // Accumulator width: one lane sum plus 8 bits of beat headroom.
  function automatic int acc_w_default(input int width, input int lanes);
    return lane_w(width) + $clog2(lanes) + 8;
  endfunction

endpackage

// File: rtl/head_prune_accum_abs_sum_tree.sv
// Stages 1-2: registered per-lane absolute value, then registered lane sum.
module abs_sum_tree
  import head_prune_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  valid_i,
  input  logic [LANES*lane_w(WIDTH)-1:0]        data_i,
  output logic                                  s1_valid_o,
  output logic                                  sum_valid_o,
  output logic [lane_w(WIDTH)+$clog2(LANES)-1:0] sum_o
);

  localparam int LW    = lane_w(WIDTH);
  localparam int SUM_W = LW + $clog2(LANES);

  logic [LANES-1:0][LW-1:0] abs_d, abs_q;
  logic [SUM_W-1:0]         sum_d, sum_q;
  logic                     s1_q, s2_q;

  // Unsigned negate keeps the most-negative lane at 2^(LW-1) without wrapping.
  always_comb begin
    abs_d = '0;
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (data_i[i*LW+LW-1]) begin
        abs_d[i] = LW'(0) - data_i[i*LW +: LW];
      end else begin
        abs_d[i] = data_i[i*LW +: LW];
      end
      sum_d = sum_d + SUM_W'(abs_q[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      abs_q <= '0;
      sum_q <= '0;
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
    end else begin
      s1_q <= valid_i;
      s2_q <= s1_q;
      if (valid_i) abs_q <= abs_d;
      if (s1_q)    sum_q <= sum_d;
    end
  end

  assign s1_valid_o  = s1_q;
  assign sum_valid_o = s2_q;
  assign sum_o       = sum_q;

endmodule

// File: rtl/head_prune_accum.sv
// Per-head |Q*K| accumulator with saturation and threshold prune decision.
module head_prune_accum
  import head_prune_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES,
  parameter int CNT_W = 8,
  parameter int ACC_W = acc_w_default(WIDTH, LANES)
) (
  input  logic                         clk,
  input  logic                         _reset,
  input  logic                         start,
  input  logic [CNT_W-1:0]             num_beats,
  input  logic [ACC_W-1:0]             threshold,
  input  logic [4:0]                   cmp_shift,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*lane_w(WIDTH)-1:0] in_data,
  output logic                         busy,
  output logic                         done,
  output logic                         prune_head,
  output logic                         overflow
);

  localparam int SUM_W = lane_w(WIDTH) + $clog2(LANES);
  localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, nb_q, nb_d;
  logic [ACC_W-1:0]   thr_q, thr_d, acc_q, acc_d;
  logic [4:0]         sh_q, sh_d;
  logic               ovf_q, ovf_d, prune_q, prune_d, done_q, done_d;

  logic               accept_s, s1_valid_s, sum_valid_s;
  logic [SUM_W-1:0]   sum_s;
  logic [EXT_W-1:0]   tot_s;
  logic [CNT_W:0]     cnt_inc_s;

  assign accept_s  = in_valid && in_ready;
  assign tot_s     = EXT_W'(acc_q) + EXT_W'(sum_s);
  assign cnt_inc_s = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  abs_sum_tree #(.WIDTH(WIDTH), .LANES(LANES)) u_tree (
    .clk_i       (clk),
    .rst_ni      (_reset),
    .valid_i     (accept_s),
    .data_i      (in_data),
    .s1_valid_o  (s1_valid_s),
    .sum_valid_o (sum_valid_s),
    .sum_o       (sum_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nb_d    = nb_q;
    thr_d   = thr_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    prune_d = prune_q;
    done_d  = 1'b0;

    if (sum_valid_s) begin
      if (tot_s > EXT_W'(ACC_MAX)) begin
        acc_d = ACC_MAX;
        ovf_d = 1'b1;
      end else begin
        acc_d = tot_s[ACC_W-1:0];
      end
    end else begin
      acc_d = acc_q;
    end

    // DRAIN leaves once stage 1 is empty: the final sum lands in acc on that same edge.
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          nb_d    = num_beats;
          thr_d   = threshold;
          sh_d    = cmp_shift;
          cnt_d   = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
          prune_d = 1'b0;
          state_d = (num_beats == '0) ? COMPARE : ACCUM;
        end else begin
          state_d = state_q;
        end
      end
      ACCUM: begin
        if (accept_s) begin
          cnt_d = cnt_inc_s[CNT_W-1:0];
          if (cnt_inc_s == {1'b0, nb_q}) state_d = DRAIN;
          else                           state_d = ACCUM;
        end else begin
          state_d = ACCUM;
        end
      end
      DRAIN: begin
        if (!s1_valid_s) state_d = COMPARE;
        else             state_d = DRAIN;
      end
      COMPARE: begin
        prune_d = ((acc_q >> sh_q) <= thr_q);
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nb_q    <= '0;
      thr_q   <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      prune_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nb_q    <= nb_d;
      thr_q   <= thr_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      prune_q <= prune_d;
      done_q  <= done_d;
    end
  end

  assign in_ready   = (state_q == ACCUM);
  assign busy       = (state_q == ACCUM) || (state_q == DRAIN) || (state_q == COMPARE);
  assign done       = done_q;
  assign prune_head = prune_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_head_prune_accum.sv
// Directed bench for head_prune_accum: default instance plus a narrow-accumulator instance.
module tb_head_prune_accum;

  localparam int WIDTH = 8;
  localparam int LANES = 32;
  localparam int DW    = LANES * 2 * WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start, in_valid, in_ready, busy, done, prune_head, overflow;
  logic [7:0]    num_beats;
  logic [28:0]   threshold;
  logic [4:0]    cmp_shift;
  logic [DW-1:0] in_data;

  logic          s_start, s_valid, s_ready, s_busy, s_done, s_prune, s_ovf;
  logic [7:0]    s_nb;
  logic [19:0]   s_thr;
  logic [4:0]    s_sh;
  logic [DW-1:0] s_data;

  int tests = 0;
  int fails = 0;
  int k;

  head_prune_accum #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(8)) u_dut (
    .clk(clk), ._reset(rst_n), .start(start), .num_beats(num_beats),
    .threshold(threshold), .cmp_shift(cmp_shift), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .busy(busy), .done(done),
    .prune_head(prune_head), .overflow(overflow)
  );

  head_prune_accum #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(8), .ACC_W(20)) u_sat (
    .clk(clk), ._reset(rst_n), .start(s_start), .num_beats(s_nb),
    .threshold(s_thr), .cmp_shift(s_sh), .in_valid(s_valid),
    .in_ready(s_ready), .in_data(s_data), .busy(s_busy), .done(s_done),
    .prune_head(s_prune), .overflow(s_ovf)
  );

  function automatic logic [DW-1:0] fill(input logic [15:0] even_v, input logic [15:0] odd_v);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < LANES; i++) d[i*16 +: 16] = (i % 2 == 0) ? even_v : odd_v;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] nb, input logic [28:0] thr, input logic [4:0] sh);
    start = 1'b1; num_beats = nb; threshold = thr; cmp_shift = sh;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic v);
    in_valid = v; in_data = d;
    @(negedge clk);
  endtask

  // Entered at the negedge right after the last accept edge; k counts negedges to done.
  task automatic wait_done(output int n);
    in_valid = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_beats = '0; threshold = '0; cmp_shift = '0;
    in_valid = 1'b0; in_data = '0;
    s_start = 1'b0; s_nb = '0; s_thr = '0; s_sh = '0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_prune", prune_head, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 4 beats of +3 x 32 lanes = 384
    do_start(8'd4, 29'd384, 5'd0);
    chk("t1_busy", busy, 1);
    chk("t1_in_ready", in_ready, 1);
    repeat (4) beat(fill(16'd3, 16'd3), 1'b1);
    wait_done(k);
    chk("t1_latency", k, 4);
    chk("t1_prune", prune_head, 1);
    chk("t1_overflow", overflow, 0);
    chk("t1_idle", busy, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_prune_held", prune_head, 1);

    // 32 * 32768 = 1048576, >> 8 = 4096
    do_start(8'd1, 29'd4096, 5'd8);
    beat(fill(16'h8000, 16'h8000), 1'b1);
    wait_done(k);
    chk("t2_latency", k, 4);
    chk("t2_prune", prune_head, 1);
    chk("t2_overflow", overflow, 0);

    // Start lands in the done cycle: accepted, prune cleared
    chk("t1b_done_high", done, 1);
    do_start(8'd4, 29'd383, 5'd0);
    chk("t1b_prune_cleared", prune_head, 0);
    chk("t1b_busy", busy, 1);
    repeat (4) beat(fill(16'd3, 16'd3), 1'b1);
    wait_done(k);
    chk("t1b_latency", k, 4);
    chk("t1b_prune", prune_head, 0);

    // +5/-5 lanes: 160 per beat, 320 over 2 beats; gaps and an ignored start
    do_start(8'd2, 29'd319, 5'd0);
    beat(fill(16'd5, 16'hFFFB), 1'b1);
    start = 1'b1; num_beats = 8'd1; threshold = 29'd1000;
    beat(fill(16'd5, 16'hFFFB), 1'b0);
    start = 1'b0;
    beat(fill(16'd5, 16'hFFFB), 1'b0);
    chk("t3_still_accum", in_ready, 1);
    beat(fill(16'd5, 16'hFFFB), 1'b1);
    wait_done(k);
    chk("t3_latency", k, 4);
    chk("t3_prune", prune_head, 0);

    // ACC_W=20: 2 x 1048544 saturates to 0xFFFFF > 0xFFFFE
    s_start = 1'b1; s_nb = 8'd2; s_thr = 20'hFFFFE; s_sh = 5'd0;
    @(negedge clk);
    s_start = 1'b0; s_valid = 1'b1; s_data = fill(16'h7FFF, 16'h7FFF);
    repeat (2) @(negedge clk);
    s_valid = 1'b0;
    k = 1;
    while (!s_done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t4_latency", k, 4);
    chk("t4_prune", s_prune, 0);
    chk("t4_overflow", s_ovf, 1);
    s_start = 1'b1; s_nb = 8'd0; s_thr = 20'd0;
    @(negedge clk);
    s_start = 1'b0;
    chk("t4_overflow_cleared", s_ovf, 0);

    // Zero beats: done two cycles after start, in_ready never high
    do_start(8'd0, 29'd0, 5'd0);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_done_early", done, 0);
    wait_done(k);
    chk("t5_latency", k, 2);
    chk("t5_prune", prune_head, 1);
    chk("t5_in_ready_end", in_ready, 0);

    // Reset after 1 of 3 beats
    @(negedge clk);
    do_start(8'd3, 29'd31, 5'd0);
    beat(fill(16'd1, 16'd1), 1'b1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_in_ready", in_ready, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_prune", prune_head, 0);
    chk("t6_overflow", overflow, 0);
    rst_n = 1'b1;
    k = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) k++;
    end
    chk("t6_no_done", k, 0);
    do_start(8'd1, 29'd31, 5'd0);
    beat(fill(16'd1, 16'd1), 1'b1);
    wait_done(k);
    chk("t6_latency", k, 4);
    chk("t6_prune", prune_head, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
